lsu_dmem: RTL and testbench
===========================

Name: lsu_dmem

Overview:
- Multi-cycle load/store unit directly downstream of the ALU in the RISC-V CPU.
- Takes the effective address (AluOut), store data (dR2) and funct3 for LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives a word-organised data RAM over a req/ack handshake, stalls the program counter while busy, and returns sign- or zero-extended load data to the register write-back mux (writesel = 2'b10 path).

Parameters:
- n, 32, data/address width (fixed at 32 for RV32I byte lanes).
- alen, 6, data RAM word-address width.
- tmo, 15, max cycles waiting for mem_ack before fault; counter width $clog2(tmo+1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request from decoder; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  instr[14:12] access size/sign.
- addr  in  n  effective byte address (AluOut).
- wdata  in  n  store data (dR2).
- rdata  out  n  extended load data, registered.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; misaligned, illegal funct3 or timeout.
- stall  out  1  hold PC/instruction while access is outstanding.
- mem_req  out  1  RAM request, held until mem_ack.
- mem_we  out  1  RAM write enable.
- mem_be  out  4  byte enables, bit i = byte lane i.
- mem_addr  out  alen  word address = addr[alen+1:2].
- mem_wdata  out  n  lane-replicated store data.
- mem_rdata  in  n  RAM read word, valid with mem_ack.
- mem_ack  in  1  RAM completion.

Behaviour:
- Reset (reset=0, async): state IDLE. rdata, done, fault, mem_req, mem_we, mem_be, mem_addr, mem_wdata and the timeout counter all go to 0. An in-flight mem_req drops immediately, with no completion.
- State IDLE:
  - On req, check legality:
    - illegal funct3 (load 011/110/111; store anything other than 000/001/010);
    - half access with addr[0]=1;
    - word access with addr[1:0]!=0.
  - Illegal request -> FAULT. Legal request -> latch we/funct3/addr[1:0]/word address and build be/wdata -> BUS.
- State BUS:
  - mem_req=1; mem_we, mem_be, mem_addr and mem_wdata are stable from registers.
  - On mem_ack -> RESP. For a load, rdata captures the extended value in that edge.
  - If the counter reaches tmo without ack -> FAULT; mem_req drops.
  - The counter clears on BUS entry.
- State RESP: done=1, fault=0 -> IDLE.
- State FAULT: done=1, fault=1, mem_req never asserted for that access; rdata unchanged -> IDLE.
- stall = (state==IDLE & req) | state==BUS | (state==FAULT? 0). stall is 0 in RESP and FAULT so the PC advances on the done cycle.
- Latency: a zero-wait RAM (ack in the first BUS cycle) gives done two cycles after req. Each wait cycle adds one.
- req outside IDLE is ignored. req in the done cycle is ignored (state is not IDLE).
- Store byte enables:
  - SB: mem_be = 1<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111; mem_wdata = wdata.
- Loads: mem_be = 1111 and mem_we = 0. Lane select uses addr[1:0].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- rdata holds until the next successful load completes. Stores do not modify rdata.
- addr bits above alen+1 are ignored (wrap within RAM).

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, BUS, RESP, FAULT};
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One combinational sub-module, lsu_align:
  - store side: funct3, addr[1:0], wdata -> be, lane-replicated wdata, legal flag;
  - load side: funct3, addr[1:0], mem_rdata -> extended load value.
- The FSM and timeout counter stay in lsu_dmem.

Test Plan:
- LW addr=0x0000_0010, mem_rdata=0x1234_5678, ack in first BUS cycle -> mem_addr=4, mem_be=1111, done at cycle 2, rdata=0x1234_5678, fault=0.
- LB addr=0x13, mem_rdata=0x80FF_1234 -> rdata=0xFFFF_FF80. Repeat as LBU -> rdata=0x0000_0080. LH addr=0x12 with mem_rdata=0x80FF_0000 -> rdata=0xFFFF_80FF.
- SH addr=0x0A, wdata=0xDEAD_BEEF -> mem_we=1, mem_addr=2, mem_be=1100, mem_wdata=0xBEEF_BEEF, rdata unchanged.
- LW addr=0x06 -> mem_req never asserted, done=1 and fault=1 one cycle after req, stall=1 only in the req cycle. funct3=011 load -> same.
- SW with ack delayed 3 cycles -> mem_req and stall high for 4 BUS cycles with stable outputs, done on the cycle after ack. ack never -> fault after tmo=15 cycles.
- reset asserted low mid-BUS -> mem_req, stall and done 0 immediately. After release, a new LW completes normally with no stale done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states and the
// RV32I funct3 encodings for the supported access sizes.
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store byte enables, lane
// replication and legality on one side, load lane select and extension on the other.
module lsu_align
  import lsu_pkg::*;
(
  input  logic             st_we_i,
  input  logic [2:0]       st_funct3_i,
  input  logic [1:0]       st_lo_i,
  input  logic [XLEN-1:0]  st_wdata_i,
  output logic [3:0]       st_be_o,
  output logic [XLEN-1:0]  st_wdata_o,
  output logic             st_legal_o,
  input  logic [2:0]       ld_funct3_i,
  input  logic [1:0]       ld_lo_i,
  input  logic [XLEN-1:0]  ld_rdata_i,
  output logic [XLEN-1:0]  ld_data_o
);

  logic [XLEN-1:0] lane;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_wdata_i;
    st_legal_o = 1'b0;
    case (st_funct3_i)
      F3_B: begin
        st_legal_o = 1'b1;
        if (st_we_i) begin
          st_be_o    = 4'b0001 << st_lo_i;
          st_wdata_o = {4{st_wdata_i[7:0]}};
        end
      end
      F3_H: begin
        st_legal_o = ~st_lo_i[0];
        if (st_we_i) begin
          st_be_o    = st_lo_i[1] ? 4'b1100 : 4'b0011;
          st_wdata_o = {2{st_wdata_i[15:0]}};
        end
      end
      F3_W:    st_legal_o = (st_lo_i == 2'b00);
      F3_BU:   st_legal_o = ~st_we_i;
      F3_HU:   st_legal_o = ~st_we_i & ~st_lo_i[0];
      default: st_legal_o = 1'b0;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by access type.
  always_comb begin
    lane      = ld_rdata_i >> {ld_lo_i, 3'b000};
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    ld_data_o = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   ld_data_o = {24'd0, lane[7:0]};
      F3_HU:   ld_data_o = {16'd0, lane[15:0]};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_dmem.sv
// Multi-cycle load/store unit: checks legality, drives the word RAM over
// mem_req/mem_ack, stalls the PC while busy and returns extended load data.
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int n    = 32,
  parameter int alen = 6,
  parameter int tmo  = 15
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [2:0]      funct3_i,
  input  logic [n-1:0]    addr_i,
  input  logic [n-1:0]    wdata_i,
  output logic [n-1:0]    rdata_o,
  output logic            done_o,
  output logic            fault_o,
  output logic            stall_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [alen-1:0] mem_addr_o,
  output logic [n-1:0]    mem_wdata_o,
  input  logic [n-1:0]    mem_rdata_i,
  input  logic            mem_ack_i,
  output logic [1:0]      state_o
);

  localparam int CW = $clog2(tmo + 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      lo_q;
  logic [alen-1:0] mem_addr_q;
  logic [3:0]      mem_be_q;
  logic [n-1:0]    mem_wdata_q, rdata_q;
  logic            mem_req_q, done_q, fault_q;

  logic [3:0]      st_be;
  logic [n-1:0]    st_wdata, ld_data;
  logic            st_legal;
  logic            unused_addr;

  assign unused_addr = ^addr_i[n-1:alen+2];
  assign cnt_d       = cnt_q + CW'(1);

  lsu_align u_align (
    .st_we_i     (we_i),
    .st_funct3_i (funct3_i),
    .st_lo_i     (addr_i[1:0]),
    .st_wdata_i  (wdata_i),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .st_legal_o  (st_legal),
    .ld_funct3_i (f3_q),
    .ld_lo_i     (lo_q),
    .ld_rdata_i  (mem_rdata_i),
    .ld_data_o   (ld_data)
  );

  // Handshake: mem_req rises on BUS entry and stays high with stable
  // we/be/addr/wdata until the edge on which mem_ack is sampled high
  // (or the wait budget runs out); mem_rdata is only used on that edge.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      lo_q        <= 2'd0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            if (!st_legal) begin
              state_q <= FAULT;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q     <= BUS;
              we_q        <= we_i;
              f3_q        <= funct3_i;
              lo_q        <= addr_i[1:0];
              mem_addr_q  <= addr_i[alen+1:2];
              mem_be_q    <= st_be;
              mem_wdata_q <= st_wdata;
              mem_req_q   <= 1'b1;
              cnt_q       <= '0;
            end
          end
        end
        BUS: begin
          if (mem_ack_i) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            if (!we_q) rdata_q <= ld_data;
          end else if (cnt_d == CW'(tmo)) begin
            state_q   <= FAULT;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            fault_q   <= 1'b1;
            cnt_q     <= cnt_d;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP:    state_q <= IDLE;
        FAULT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o     = reset_i & (((state_q == IDLE) & req_i) | (state_q == BUS));
  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: transaction-level model predicts every cycle of each
// access; a negedge compare process checks the DUT against it.
module tb_lsu_dmem;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset_i, req_i, we_i, mem_ack_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic [31:0] rdata_o, mem_wdata_o;
  logic        done_o, fault_o, stall_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [5:0]  mem_addr_o;
  logic [1:0]  dbg_state;

  lsu_dmem #(.n(32), .alen(6), .tmo(TMO)) dut (
    .clock_i     (clk),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .done_o      (done_o),
    .fault_o     (fault_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .state_o     (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model-predicted outputs for the current cycle
  logic        exp_done, exp_fault, exp_stall, exp_mem_req, exp_we, exp_chk_wd;
  logic [3:0]  exp_be;
  logic [5:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic [31:0] rdata_model;
  logic [31:0] exp_q[$];

  // last bus beat seen, for literal checks of directed cases
  logic        cap_we;
  logic [3:0]  cap_be;
  logic [5:0]  cap_addr;
  logic [31:0] cap_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("done", {31'd0, done_o}, {31'd0, exp_done});
    chk("fault", {31'd0, fault_o}, {31'd0, exp_fault});
    chk("stall", {31'd0, stall_o}, {31'd0, exp_stall});
    chk("mem_req", {31'd0, mem_req_o}, {31'd0, exp_mem_req});
    chk("rdata", rdata_o, rdata_model);
    if (exp_mem_req) begin
      chk("mem_we", {31'd0, mem_we_o}, {31'd0, exp_we});
      chk("mem_be", {28'd0, mem_be_o}, {28'd0, exp_be});
      chk("mem_addr", {26'd0, mem_addr_o}, {26'd0, exp_addr});
      if (exp_chk_wd) chk("mem_wdata", mem_wdata_o, exp_wdata);
    end
    if (mem_req_o) begin
      cap_we = mem_we_o; cap_be = mem_be_o; cap_addr = mem_addr_o; cap_wdata = mem_wdata_o;
    end
  end

  function automatic bit model_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 1'b1;
      3'd1:    return (a % 2) == 0;
      3'd2:    return (a % 4) == 0;
      3'd4:    return !we;
      3'd5:    return !we && ((a % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (8 * (a % 4))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!we || f3 == 3'd2) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << (a % 4));
    return ((a % 4) >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic set_idle_exp();
    exp_done = 0; exp_fault = 0; exp_stall = 0; exp_mem_req = 0;
  endtask

  task automatic noise();
    req_i    = 1'($urandom_range(0, 1));
    we_i     = 1'($urandom_range(0, 1));
    funct3_i = 3'($urandom_range(0, 7));
    addr_i   = $urandom;
    wdata_i  = $urandom;
  endtask

  // One access; delay = wait cycles before ack, delay >= TMO means no ack.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rword, input int delay);
    int k;
    req_i = 1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
    mem_ack_i = 0; mem_rdata_i = $urandom;
    exp_done = 0; exp_fault = 0; exp_stall = 1; exp_mem_req = 0;
    @(posedge clk); #1;
    if (!model_legal(we, f3, a)) begin
      noise();
      exp_stall = 0; exp_done = 1; exp_fault = 1;
      @(posedge clk); #1;
    end else begin
      k = (delay < TMO) ? delay + 1 : TMO;
      for (int c = 1; c <= k; c++) begin
        noise();
        mem_ack_i   = (c == delay + 1);
        mem_rdata_i = (c == delay + 1) ? rword : $urandom;
        exp_stall = 1; exp_mem_req = 1; exp_done = 0; exp_fault = 0;
        exp_we = we; exp_be = model_be(we, f3, a); exp_addr = 6'((a >> 2) % 64);
        exp_wdata = model_wd(f3, wd); exp_chk_wd = we;
        @(posedge clk); #1;
      end
      noise();
      mem_ack_i = 0; mem_rdata_i = $urandom;
      exp_stall = 0; exp_mem_req = 0; exp_done = 1;
      exp_fault = (delay >= TMO);
      if (delay < TMO && !we) begin
        exp_q.push_back(model_load(f3, a, rword));
        rdata_model = exp_q.pop_front();
      end
      @(posedge clk); #1;
    end
    req_i = 0;
    set_idle_exp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    int          d;
    reset_i = 0; req_i = 0; we_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0; rdata_model = 0;
    exp_we = 0; exp_be = 0; exp_addr = 0; exp_wdata = 0; exp_chk_wd = 0;
    set_idle_exp();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_be", {28'd0, mem_be_o}, 32'h0);
    reset_i = 1;
    @(posedge clk); #1;

    access(0, 3'b010, 32'h0000_0010, 32'h0, 32'h1234_5678, 0);
    chk("lw_rdata", rdata_o, 32'h1234_5678);
    chk("lw_addr", {26'd0, cap_addr}, 32'd4);
    chk("lw_be", {28'd0, cap_be}, 32'hF);
    access(0, 3'b000, 32'h13, 32'h0, 32'h80FF_1234, 1);
    chk("lb_rdata", rdata_o, 32'hFFFF_FF80);
    access(0, 3'b100, 32'h13, 32'h0, 32'h80FF_1234, 0);
    chk("lbu_rdata", rdata_o, 32'h0000_0080);
    access(0, 3'b001, 32'h12, 32'h0, 32'h80FF_0000, 2);
    chk("lh_rdata", rdata_o, 32'hFFFF_80FF);
    access(1, 3'b001, 32'h0A, 32'hDEAD_BEEF, 32'h5555_5555, 0);
    chk("sh_we", {31'd0, cap_we}, 32'd1);
    chk("sh_addr", {26'd0, cap_addr}, 32'd2);
    chk("sh_be", {28'd0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    chk("sh_rdata_kept", rdata_o, 32'hFFFF_80FF);
    access(0, 3'b010, 32'h06, 32'h0, 32'h0, 0);
    access(0, 3'b011, 32'h08, 32'h0, 32'h0, 0);
    access(1, 3'b010, 32'h3C, 32'hA5A5_0F0F, 32'h0, 3);
    access(1, 3'b000, 32'h3D, 32'h0000_00C3, 32'h0, 99);

    // reset in the middle of a bus access
    req_i = 1; we_i = 0; funct3_i = 3'b010; addr_i = 32'h20;
    exp_stall = 1;
    @(posedge clk); #1;
    req_i = 0; mem_ack_i = 0;
    exp_mem_req = 1; exp_we = 0; exp_be = 4'hF; exp_addr = 6'd8; exp_chk_wd = 0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_i = 0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    rdata_model = 0;
    set_idle_exp();
    @(posedge clk); #1;
    reset_i = 1;
    @(posedge clk); #1;
    access(0, 3'b010, 32'h24, 32'h0, 32'hCAFE_F00D, 1);
    chk("post_rst_lw", rdata_o, 32'hCAFE_F00D);

    for (int i = 0; i < 200; i++) begin
      a  = $urandom;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d  = ($urandom_range(0, 15) == 0) ? 99 : int'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom, d);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
